// File: rtl/lstm_state_stack.sv
// ============================================================================
// lstm_state_stack : LIFO per-timestep record buffer for LSTM BPTT replay
// Revision 1.0
// ============================================================================
`default_nettype none

module lstm_state_stack #(
  parameter int WIDTH          = 32,
  parameter int NUM_LSTM       = 1,
  parameter int NUM_ITERATIONS = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_push,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_a,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_i,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_f,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_o,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_c,
  input  logic [NUM_LSTM*WIDTH-1:0]              i_h,
  input  logic                                   i_flush,
  input  logic                                   i_pop,
  output logic                                   o_valid,
  output logic [NUM_LSTM*WIDTH-1:0]              o_a,
  output logic [NUM_LSTM*WIDTH-1:0]              o_i,
  output logic [NUM_LSTM*WIDTH-1:0]              o_f,
  output logic [NUM_LSTM*WIDTH-1:0]              o_o,
  output logic [NUM_LSTM*WIDTH-1:0]              o_c,
  output logic [NUM_LSTM*WIDTH-1:0]              o_h,
  output logic [NUM_LSTM*WIDTH-1:0]              o_c_prev,
  output logic                                   o_last,
  output logic                                   o_full,
  output logic                                   o_empty,
  output logic [$clog2(NUM_ITERATIONS+1)-1:0]    o_count,
  output logic                                   o_err
);

  localparam int VW = NUM_LSTM * WIDTH;
  localparam int CW = $clog2(NUM_ITERATIONS + 1);
  localparam int IW = $clog2(NUM_ITERATIONS);

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] i;
    logic [VW-1:0] f;
    logic [VW-1:0] o;
    logic [VW-1:0] c;
    logic [VW-1:0] h;
  } rec_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  rec_t          rec_q, rec_d;
  logic [VW-1:0] c_prev_q, c_prev_d;

  rec_t          mem_q [NUM_ITERATIONS];
  logic          wr_en;
  rec_t          wr_rec;
  logic [IW-1:0] cnt_lo;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_prev_idx;

  // Modulo-2^IW arithmetic stays correct because count never exceeds NUM_ITERATIONS.
  assign cnt_lo      = count_q[IW-1:0];
  assign rd_idx      = cnt_lo - IW'(1);
  assign rd_prev_idx = cnt_lo - IW'(2);
  assign wr_rec      = '{a: i_a, i: i_i, f: i_f, o: i_o, c: i_c, h: i_h};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    rec_d    = rec_q;
    c_prev_d = c_prev_q;
    wr_en    = 1'b0;
    case (state_q)
      FILL: begin
        if (i_pop) err_d = 1'b1;
        if (i_push) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
        if ((i_push && (count_q == CW'(NUM_ITERATIONS - 1))) ||
            (i_flush && (i_push || (count_q != '0))))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (i_push) err_d = 1'b1;
        if (i_pop) begin
          valid_d  = 1'b1;
          rec_d    = mem_q[rd_idx];
          c_prev_d = (count_q > CW'(1)) ? mem_q[rd_prev_idx].c : '0;
          last_d   = (count_q == CW'(1));
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      count_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      rec_q    <= '0;
      c_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      rec_q    <= rec_d;
      c_prev_q <= c_prev_d;
    end
  end

  // Record storage deliberately has no reset; only pointers and outputs do.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_lo] <= wr_rec;
  end

  assign o_valid  = valid_q;
  assign o_a      = rec_q.a;
  assign o_i      = rec_q.i;
  assign o_f      = rec_q.f;
  assign o_o      = rec_q.o;
  assign o_c      = rec_q.c;
  assign o_h      = rec_q.h;
  assign o_c_prev = c_prev_q;
  assign o_last   = last_q;
  assign o_full   = (state_q == DRAIN);
  assign o_empty  = (count_q == '0);
  assign o_count  = count_q;
  assign o_err    = err_q;

endmodule

`default_nettype wire

// File: doc/lstm_state_stack.md
# lstm_state_stack

Per-timestep state buffer for LSTM backpropagation-through-time. During the forward pass it captures one record per timestep: the gate activations a, i, f, o, the cell state c and the hidden output h from the LSTM core. During the backward pass it replays those records in reverse order (LIFO). Each replayed record is paired with the previous timestep's cell state, which the gradient datapath needs to compute the forget-gate term. The block sits between the forward LSTM instance and the backprop delta/weight-update logic, and is the read-back counterpart of the forward input sequencing.

## Interface
Parameters:
- WIDTH, 32, fixed-point word width
- NUM_LSTM, 1, number of LSTM cells per record vector
- NUM_ITERATIONS, 8, stack depth in timesteps (≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_push  in  1  capture one forward record this cycle
- i_a, i_i, i_f, i_o, i_c, i_h  in  NUM_LSTM*WIDTH each  forward record fields, signed
- i_flush  in  1  end forward pass early and enter drain with the current contents
- i_pop  in  1  request the newest stored record
- o_valid  out  1  o_* record fields valid this cycle
- o_a, o_i, o_f, o_o, o_c, o_h  out  NUM_LSTM*WIDTH each  replayed record fields
- o_c_prev  out  NUM_LSTM*WIDTH  c of the entry below the popped one; 0 when entry 0 is popped
- o_last  out  1  with o_valid: popped entry was index 0
- o_full  out  1  state is DRAIN
- o_empty  out  1  count == 0
- o_count  out  $clog2(NUM_ITERATIONS+1)  stored entries
- o_err  out  1  sticky protocol error

## Operation
- Storage: NUM_ITERATIONS entries, each holding {a,i,f,o,c,h}. Memory contents are not cleared by reset; only pointers, state and outputs reset.
- FSM has two states, FILL and DRAIN. Reset state is FILL.
- FILL behaviour:
  - i_push writes entry[count] and count increments.
  - When a push makes count == NUM_ITERATIONS, the next state is DRAIN.
  - i_flush with count > 0 moves to DRAIN. i_flush with count == 0 is ignored; no error.
  - i_pop is ignored and sets o_err.
- DRAIN behaviour:
  - i_pop reads entry[count-1] and entry[count-2] (or 0 when count-1 == 0) and decrements count.
  - The pop that makes count == 0 returns to FILL.
  - i_push is ignored and sets o_err. i_flush is ignored.
- Push and pop asserted in the same cycle: only the operation legal in the current state takes effect; the other sets o_err.
- i_push with i_flush in FILL: the push is written first, then the state moves to DRAIN.
- o_err clears only on rst.
- o_count increments and decrements by 1, with no wrap. Count 0..NUM_ITERATIONS covers all legal values.
- Data is passed bit-exact; there is no arithmetic on record fields.

## Timing
- Reset values: o_valid=0, o_last=0, all data outputs 0, o_count=0, o_empty=1, o_full=0, o_err=0.
- Push at edge N: o_count and o_empty are updated after edge N. The entry can be popped at the earliest at N+1 if the state is DRAIN.
- Pop accepted at edge N: o_valid=1 with data, o_c_prev and o_last for the cycle after edge N. o_valid is a 1-cycle pulse unless pops continue back-to-back.
- Data outputs hold their last value while o_valid=0.
- Back-to-back pops sustain 1 record/cycle. Latency is 1 cycle.
- o_full rises the cycle after the filling push or flush. It falls the cycle after the final pop, the same cycle o_valid/o_last show entry 0.
- rst mid-drain: after the reset edge, state is FILL, count is 0 and o_valid is 0. A pop in the same cycle as rst is discarded.

## Test plan
- Full cycle: push 8 records with c=h=a=…=t+1 for t=0..7, then pop 8 times back-to-back. Expect o_c = 8,7,…,1; o_c_prev = 7,6,…,1,0; o_last only on the 8th o_valid; o_full=1 from the cycle after the 8th push to the cycle after the 8th pop; o_err=0.
- Flush: push 3 records (c=10,20,30), assert i_flush, then pop 3 times. Expect o_c = 30,20,10; o_c_prev = 20,10,0; o_last on the third; state returns to FILL with o_empty=1.
- Illegal ops: pop in FILL with count=2 leaves count at 2 and sets o_err=1. Push in DRAIN leaves count unchanged and leaves o_err set. Verify o_err stays 1 until rst.
- Push with flush in the same cycle after 4 pushes: count=5, then DRAIN. The first pop returns the 5th record.
- Reset mid-drain: fill 8 records, pop 3, assert rst for 1 cycle. Expect o_count=0, o_valid=0, o_full=0, o_err=0. A subsequent 8-push/8-pop sequence with new data returns the new data correctly.
- Gapped pops: in DRAIN, pop with 2 idle cycles between pops. Expect o_valid pulses of 1 cycle, data held between pulses, and correct reverse order.
